// File: rtl/lab62soc_mem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// lab62soc_mem_arb_pkg
// Shared types and constants for the on-chip RAM arbiter slice:
//   state_e   - sequencer states (RST, CLEAR, RUN)
//   req_id_t  - requester id (0 = m0, 1 = m1)
//   DEF_*     - default address/data widths
//   depth()   - word count for a given address width
// ---------------------------------------------------------------------------
package lab62soc_mem_arb_pkg;

    localparam int DEF_ADDR_W = 2;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        RST   = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2
    } state_e;

    typedef logic req_id_t;

    function automatic int depth(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/lab62soc_mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// lab62soc_mem_arbiter_if
// Avalon-MM-style requester bus for one master of the RAM arbiter.
//   address/byteenable/read/write/writedata : command, driven by the master
//   waitrequest                              : 1 = command not accepted
//   readdata/readdatavalid                   : read return, fixed latency
// Modports: master (requester side), slave (arbiter side).
// ---------------------------------------------------------------------------
interface lab62soc_mem_arbiter_if
    import lab62soc_mem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) ();

    localparam int BE_W = DATA_W / 8;

    logic [ADDR_W-1:0] address;
    logic [BE_W-1:0]   byteenable;
    logic              read;
    logic              write;
    logic [DATA_W-1:0] writedata;
    logic              waitrequest;
    logic [DATA_W-1:0] readdata;
    logic              readdatavalid;

    modport master (
        output address, byteenable, read, write, writedata,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  address, byteenable, read, write, writedata,
        output waitrequest, readdata, readdatavalid
    );

endinterface

// File: rtl/lab62soc_mem_arbiter_rr_arb2.sv
// ---------------------------------------------------------------------------
// lab62soc_rr_arb2
// Two-way round-robin grant logic with its priority pointer.
//   clk, rst_n     : clock, asynchronous active-low reset
//   en             : 1 = grants may be issued this cycle
//   req0, req1     : requests from m0 / m1
//   gnt0, gnt1     : one-hot grant (combinational, same cycle)
//   gnt_any        : a grant was issued
//   gnt_id         : id of the granted master (valid when gnt_any)
// ---------------------------------------------------------------------------
module lab62soc_rr_arb2
    import lab62soc_mem_arb_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  logic    en,
    input  logic    req0,
    input  logic    req1,
    output logic    gnt0,
    output logic    gnt1,
    output logic    gnt_any,
    output req_id_t gnt_id
);

    // Side that wins a tie; 0 = m0.
    req_id_t ptr;

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (en) begin
            if (req0 && req1) begin
                gnt0 = (ptr == 1'b0);
                gnt1 = (ptr == 1'b1);
            end else begin
                gnt0 = req0;
                gnt1 = req1;
            end
        end
    end

    assign gnt_any = gnt0 | gnt1;
    assign gnt_id  = req_id_t'(gnt1);

    // After a grant the other master gets priority; held when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= 1'b0;
        end else if (gnt_any) begin
            ptr <= req_id_t'(gnt0);
        end
    end

endmodule

// File: rtl/lab62soc_mem_arbiter.sv
// ---------------------------------------------------------------------------
// lab62soc_mem_arbiter
// Shares a single-port on-chip RAM between two requesters. After reset the
// RAM is optionally zero-filled, then commands are granted round-robin at one
// per cycle. Read data returns one cycle after the grant.
//   clk, reset_n   : clock, asynchronous active-low reset
//   freeze         : 1 = issue no new grants
//   m0, m1         : requester buses (slave modport)
//   mem_*          : RAM port (address/byteenable/chipselect/write/
//                    writedata/clken out, readdata in)
//   init_done      : 1 once the sequencer is in RUN
// ---------------------------------------------------------------------------
module lab62soc_mem_arbiter
    import lab62soc_mem_arb_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int BE_W       = DATA_W / 8,
    parameter bit INIT_CLEAR = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  freeze,
    lab62soc_mem_arbiter_if.slave m0,
    lab62soc_mem_arbiter_if.slave m1,
    output logic [ADDR_W-1:0]     mem_address,
    output logic [BE_W-1:0]       mem_byteenable,
    output logic                  mem_chipselect,
    output logic                  mem_write,
    output logic [DATA_W-1:0]     mem_writedata,
    output logic                  mem_clken,
    input  logic [DATA_W-1:0]     mem_readdata,
    output logic                  init_done
);

    localparam int DEPTH = depth(ADDR_W);

    state_e            state;
    state_e            state_nxt;
    logic [ADDR_W-1:0] clr_cnt;

    logic    arb_en;
    logic    gnt0;
    logic    gnt1;
    logic    gnt_any;
    req_id_t gnt_id;

    logic [ADDR_W-1:0] win_address;
    logic [BE_W-1:0]   win_byteenable;
    logic [DATA_W-1:0] win_writedata;
    logic              win_read;
    logic              win_write;
    logic              rd_issue;

    logic    rd_pend_p1;
    req_id_t rd_id_p1;

    // State register and clear counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= RST;
            clr_cnt   <= '0;
            init_done <= 1'b0;
        end else begin
            state     <= state_nxt;
            clr_cnt   <= (state == CLEAR) ? clr_cnt + 1'b1 : '0;
            init_done <= (state_nxt == RUN);
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            RST:     state_nxt = INIT_CLEAR ? CLEAR : RUN;
            CLEAR:   if (clr_cnt == ADDR_W'(DEPTH - 1)) state_nxt = RUN;
            RUN:     state_nxt = RUN;
            default: state_nxt = RST;
        endcase
    end

    assign arb_en = (state == RUN) && !freeze;

    lab62soc_rr_arb2 u_arb (
        .clk     (clk),
        .rst_n   (reset_n),
        .en      (arb_en),
        .req0    (m0.read | m0.write),
        .req1    (m1.read | m1.write),
        .gnt0    (gnt0),
        .gnt1    (gnt1),
        .gnt_any (gnt_any),
        .gnt_id  (gnt_id)
    );

    assign win_address    = gnt_id ? m1.address    : m0.address;
    assign win_byteenable = gnt_id ? m1.byteenable : m0.byteenable;
    assign win_writedata  = gnt_id ? m1.writedata  : m0.writedata;
    assign win_read       = gnt_id ? m1.read       : m0.read;
    assign win_write      = gnt_id ? m1.write      : m0.write;

    // A command with both read and write set is treated as a write only.
    assign rd_issue = gnt_any && win_read && !win_write;

    // Output logic
    always_comb begin
        mem_chipselect = 1'b0;
        mem_write      = 1'b0;
        mem_address    = '0;
        mem_byteenable = '0;
        mem_writedata  = '0;
        m0.waitrequest = 1'b1;
        m1.waitrequest = 1'b1;
        unique case (state)
            CLEAR: begin
                mem_chipselect = 1'b1;
                mem_write      = 1'b1;
                mem_address    = clr_cnt;
                mem_byteenable = '1;
            end
            RUN: begin
                m0.waitrequest = !gnt0;
                m1.waitrequest = !gnt1;
                if (gnt_any) begin
                    mem_chipselect = 1'b1;
                    mem_write      = win_write;
                    mem_address    = win_address;
                    mem_byteenable = win_byteenable;
                    mem_writedata  = win_writedata;
                end
            end
            default: ;
        endcase
    end

    assign mem_clken = 1'b1;

    // Read return: RAM q is valid one cycle after the address is issued
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_pend_p1 <= 1'b0;
            rd_id_p1   <= 1'b0;
        end else begin
            rd_pend_p1 <= rd_issue;
            rd_id_p1   <= gnt_id;
        end
    end

    assign m0.readdatavalid = rd_pend_p1 && (rd_id_p1 == 1'b0);
    assign m1.readdatavalid = rd_pend_p1 && (rd_id_p1 == 1'b1);
    assign m0.readdata      = mem_readdata;
    assign m1.readdata      = mem_readdata;

endmodule

// File: tb/tb_lab62soc_mem_arbiter.sv
module tb_lab62soc_mem_arbiter;

    localparam int AW = 2;
    localparam int DW = 32;
    localparam int BW = DW / 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          freeze = 1'b0;
    logic [AW-1:0] mem_address;
    logic [BW-1:0] mem_byteenable;
    logic          mem_chipselect;
    logic          mem_write;
    logic [DW-1:0] mem_writedata;
    logic          mem_clken;
    logic [DW-1:0] mem_readdata;
    logic          init_done;

    lab62soc_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m0_bus ();
    lab62soc_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m1_bus ();

    lab62soc_mem_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .BE_W(BW), .INIT_CLEAR(1'b1)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .freeze         (freeze),
        .m0             (m0_bus.slave),
        .m1             (m1_bus.slave),
        .mem_address    (mem_address),
        .mem_byteenable (mem_byteenable),
        .mem_chipselect (mem_chipselect),
        .mem_write      (mem_write),
        .mem_writedata  (mem_writedata),
        .mem_clken      (mem_clken),
        .mem_readdata   (mem_readdata),
        .init_done      (init_done)
    );

    always #5 clk = ~clk;

    // Behavioural single-port RAM: registered q, byte-lane writes.
    logic [DW-1:0] ram [4];
    always @(posedge clk) begin
        if (mem_chipselect && mem_clken) begin
            mem_readdata <= ram[mem_address];
            if (mem_write) begin
                for (int b = 0; b < BW; b++)
                    if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
            end
        end
    end

    typedef struct packed {
        logic          id;
        logic [DW-1:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit id, input bit rd, input bit wr, input logic [AW-1:0] addr,
                         input logic [BW-1:0] be, input logic [DW-1:0] wd);
        if (id == 1'b0) begin
            m0_bus.read = rd; m0_bus.write = wr; m0_bus.address = addr;
            m0_bus.byteenable = be; m0_bus.writedata = wd;
        end else begin
            m1_bus.read = rd; m1_bus.write = wr; m1_bus.address = addr;
            m1_bus.byteenable = be; m1_bus.writedata = wd;
        end
    endtask

    function automatic logic wait_of(input bit id);
        return id ? m1_bus.waitrequest : m0_bus.waitrequest;
    endfunction

    // Issue one command, hold until accepted, then release it.
    task automatic do_cmd(input bit id, input bit rd, input bit wr, input logic [AW-1:0] addr,
                          input logic [BW-1:0] be, input logic [DW-1:0] wd,
                          input logic [DW-1:0] exp_rd, output int waits);
        bit got;
        got = 1'b0;
        waits = 0;
        drive(id, rd, wr, addr, be, wd);
        while (!got && waits < 20) begin
            @(negedge clk);
            if (!wait_of(id)) got = 1'b1;
            else waits++;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL grant_timeout: master %0d not granted within %0d cycles", id, waits);
        end else begin
            check("mem_chipselect_grant", 32'(mem_chipselect), 32'd1);
            check("mem_address_grant", 32'(mem_address), 32'(addr));
            check("mem_write_grant", 32'(mem_write), 32'(wr));
            if (rd && !wr) exp_q.push_back('{id: id, data: exp_rd});
        end
        @(posedge clk);
        #1;
        drive(id, 1'b0, 1'b0, '0, '0, '0);
    endtask

    // Expects to be called just after a posedge with reset_n already high.
    task automatic check_clear();
        @(posedge clk);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("clr_cs", 32'(mem_chipselect), 32'd1);
            check("clr_write", 32'(mem_write), 32'd1);
            check("clr_addr", 32'(mem_address), 32'(k));
            check("clr_data", mem_writedata, 32'd0);
            check("clr_be", 32'(mem_byteenable), 32'hF);
            check("clr_wait0", 32'(m0_bus.waitrequest), 32'd1);
            check("clr_wait1", 32'(m1_bus.waitrequest), 32'd1);
            check("clr_init_done", 32'(init_done), 32'd0);
        end
        @(negedge clk);
        check("init_done_run", 32'(init_done), 32'd1);
        check("run_idle_cs", 32'(mem_chipselect), 32'd0);
    endtask

    // Scoreboard monitor: every readdatavalid must match the queue head.
    task automatic monitor();
        exp_t e;
        logic act_id;
        logic [DW-1:0] act_data;
        forever begin
            @(negedge clk);
            if (reset_n && (m0_bus.readdatavalid || m1_bus.readdatavalid)) begin
                checks++;
                act_id   = m1_bus.readdatavalid;
                act_data = act_id ? m1_bus.readdata : m0_bus.readdata;
                if (m0_bus.readdatavalid && m1_bus.readdatavalid) begin
                    errors++;
                    $display("FAIL rdv_both: both readdatavalid high at %0t", $time);
                end else if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rdv_unexpected: id %0d data %h with nothing outstanding at %0t",
                             act_id, act_data, $time);
                end else begin
                    e = exp_q.pop_front();
                    if (act_id !== e.id || act_data !== e.data) begin
                        errors++;
                        $display("FAIL rd_return: got id %0d data %h expected id %0d data %h at %0t",
                                 act_id, act_data, e.id, e.data, $time);
                    end
                end
            end
        end
    endtask

    initial begin
        int w;
        fork
            monitor();
        join_none

        drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
        drive(1'b1, 1'b0, 1'b0, '0, '0, '0);

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_wait0", 32'(m0_bus.waitrequest), 32'd1);
        check("rst_wait1", 32'(m1_bus.waitrequest), 32'd1);
        check("rst_rdv0", 32'(m0_bus.readdatavalid), 32'd0);
        check("rst_rdv1", 32'(m1_bus.readdatavalid), 32'd0);
        check("rst_cs", 32'(mem_chipselect), 32'd0);
        check("rst_write", 32'(mem_write), 32'd0);
        check("rst_init_done", 32'(init_done), 32'd0);

        @(posedge clk);
        #1 reset_n = 1'b1;
        check_clear();

        // Both masters read continuously: grants alternate starting with m0
        @(posedge clk);
        #1;
        drive(1'b0, 1'b1, 1'b0, 2'd0, 4'hF, '0);
        drive(1'b1, 1'b1, 1'b0, 2'd1, 4'hF, '0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("alt_wait0", 32'(m0_bus.waitrequest), 32'((i % 2) != 0));
            check("alt_wait1", 32'(m1_bus.waitrequest), 32'((i % 2) != 1));
            check("alt_cs", 32'(mem_chipselect), 32'd1);
            exp_q.push_back('{id: 1'(i % 2), data: 32'd0});
        end
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
        drive(1'b1, 1'b0, 1'b0, '0, '0, '0);

        // m0 write then read of the same address on consecutive cycles
        do_cmd(1'b0, 1'b0, 1'b1, 2'd2, 4'hF, 32'hDEADBEEF, '0, w);
        check("m0_wr_waits", 32'(w), 32'd0);
        do_cmd(1'b0, 1'b1, 1'b0, 2'd2, 4'hF, '0, 32'hDEADBEEF, w);
        check("m0_rd_waits", 32'(w), 32'd0);

        // m1 partial byte-lane write
        do_cmd(1'b1, 1'b0, 1'b1, 2'd3, 4'b0101, 32'h11223344, '0, w);
        do_cmd(1'b1, 1'b1, 1'b0, 2'd3, 4'hF, '0, 32'h00220044, w);

        // read+write together is a write only (no readdatavalid)
        do_cmd(1'b0, 1'b1, 1'b1, 2'd1, 4'hF, 32'hCAFEF00D, '0, w);
        do_cmd(1'b0, 1'b1, 1'b0, 2'd1, 4'hF, '0, 32'hCAFEF00D, w);

        // Freeze right after a read grant; pointer now favours m1
        do_cmd(1'b0, 1'b1, 1'b0, 2'd2, 4'hF, '0, 32'hDEADBEEF, w);
        freeze = 1'b1;
        drive(1'b0, 1'b1, 1'b0, 2'd0, 4'hF, '0);
        drive(1'b1, 1'b1, 1'b0, 2'd3, 4'hF, '0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("frz_wait0", 32'(m0_bus.waitrequest), 32'd1);
            check("frz_wait1", 32'(m1_bus.waitrequest), 32'd1);
            check("frz_cs", 32'(mem_chipselect), 32'd0);
        end
        @(posedge clk);
        #1 freeze = 1'b0;
        @(negedge clk);
        check("unfrz_wait1", 32'(m1_bus.waitrequest), 32'd0);
        check("unfrz_wait0", 32'(m0_bus.waitrequest), 32'd1);
        exp_q.push_back('{id: 1'b1, data: 32'h00220044});
        @(posedge clk);
        #1 drive(1'b1, 1'b0, 1'b0, '0, '0, '0);
        @(negedge clk);
        check("unfrz2_wait0", 32'(m0_bus.waitrequest), 32'd0);
        exp_q.push_back('{id: 1'b0, data: 32'd0});
        @(posedge clk);
        #1 drive(1'b0, 1'b0, 1'b0, '0, '0, '0);

        // Reset with a read pending: the return is dropped
        drive(1'b0, 1'b1, 1'b0, 2'd2, 4'hF, '0);
        @(negedge clk);
        check("pre_rst_grant0", 32'(m0_bus.waitrequest), 32'd0);
        @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        check("midrst_rdv0", 32'(m0_bus.readdatavalid), 32'd0);
        check("midrst_rdv1", 32'(m1_bus.readdatavalid), 32'd0);
        check("midrst_wait0", 32'(m0_bus.waitrequest), 32'd1);
        check("midrst_wait1", 32'(m1_bus.waitrequest), 32'd1);
        check("midrst_init_done", 32'(init_done), 32'd0);
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
        @(posedge clk);
        @(posedge clk);
        #1 reset_n = 1'b1;
        check_clear();
        @(posedge clk);
        #1;
        do_cmd(1'b0, 1'b1, 1'b0, 2'd2, 4'hF, '0, 32'd0, w);

        repeat (3) @(negedge clk);
        check("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lab62soc_mem_arbiter.md
Name: lab62soc_mem_arbiter

Overview:
- Sequences and shares the SoC's 4-word single-port on-chip RAM between two Avalon-MM-style requesters (m0, m1).
- After reset it zero-fills the RAM. It then arbitrates round-robin, one transaction per cycle.
- It drives the RAM's address/byteenable/chipselect/write/writedata/clken port and returns read data with a fixed 1-cycle latency.
- It sits between the two masters and the RAM instance.

Parameters:
- ADDR_W, 2, RAM word-address width; DEPTH = 2**ADDR_W.
- DATA_W, 32, data width.
- BE_W, DATA_W/8, byteenable width.
- INIT_CLEAR, 1, 1 = zero-fill RAM after reset; 0 = go straight to RUN.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- freeze  in  1  1 = issue no new grants.
- m0_address  in  ADDR_W  word address.
- m0_byteenable  in  BE_W  write byte lanes.
- m0_read  in  1  read request.
- m0_write  in  1  write request.
- m0_writedata  in  DATA_W  write data.
- m0_waitrequest  out  1  1 = command not accepted this cycle.
- m0_readdata  out  DATA_W  read data.
- m0_readdatavalid  out  1  m0_readdata valid.
- m1_*: same set as m0_*.
- mem_address  out  ADDR_W  to RAM.
- mem_byteenable  out  BE_W  to RAM.
- mem_chipselect  out  1  to RAM.
- mem_write  out  1  to RAM.
- mem_writedata  out  DATA_W  to RAM.
- mem_clken  out  1  to RAM; tied 1.
- mem_readdata  in  DATA_W  RAM q, valid the cycle after the address is issued.
- init_done  out  1  1 once RUN is reached.

Behaviour:
- Clock is clk; reset is asynchronous, active-low (reset_n). All flops clear immediately on reset_n low.
- States: RST, CLEAR, RUN.
  - RST: reset value. The first clk edge after reset_n rises moves to CLEAR if INIT_CLEAR=1, else to RUN.
  - CLEAR: clr_cnt counts 0..DEPTH-1, one word per cycle. Drives mem_chipselect=1, mem_write=1, mem_address=clr_cnt, mem_writedata=0, mem_byteenable=all ones. Moves to RUN after word DEPTH-1.
  - RUN: normal arbitration. Left only by reset.
- Reset values: both waitrequest=1; both readdatavalid=0; mem_chipselect=0; mem_write=0; init_done=0; priority pointer = m0; read-pending flag = 0.
- In RST and CLEAR: both waitrequest=1 and no grants.
- Request: mX_req = mX_read | mX_write.
- Arbitration (RUN, freeze=0), combinational within the cycle:
  - Only one requester: it is granted.
  - Both requesting: the pointer side is granted.
  - After any grant to mX, the pointer moves to the other master. The pointer is unchanged when nothing is granted.
  - Granted master: waitrequest=0. Non-granted master: waitrequest=1 and must hold its command.
- Grant issue, same cycle: mem_chipselect=1; mem_address, mem_byteenable and mem_writedata come from the winner; mem_write = winner's write.
- read and write both asserted by one master: handled as a write only; no readdatavalid.
- Read return:
  - A granted read sets a pending flag and the id of the winner.
  - The next cycle, mX_readdatavalid=1 for that id only, and both mX_readdata = mem_readdata.
  - Back-to-back grants sustain 1 transaction per cycle.
- freeze=1 in RUN: no grants, both waitrequest=1, mem_chipselect=0, pointer held. A read granted the previous cycle still returns.
- A write followed the next cycle by a read of the same address returns the new data.
- Reset mid-operation: the pending read is dropped and readdatavalid goes 0 immediately. The FSM returns to RST and re-clears the RAM.
- init_done is registered and equals (state==RUN).

Decomposition:
- Package lab62soc_mem_arb_pkg holds:
  - state enum {RST, CLEAR, RUN};
  - requester id type (1 bit);
  - default ADDR_W/DATA_W constants and the DEPTH function.
- Sub-module: lab62soc_rr_arb2, the 2-way round-robin grant logic plus pointer flop.

Test Plan:
- Reset release, INIT_CLEAR=1 -> cycles 1-4 show mem_write=1, address 0,1,2,3, data 0. init_done=1 from cycle 5. Both waitrequest=1 until then.
- m0 writes addr 2 = 0xDEADBEEF with be 4'hF, then reads addr 2 -> each command accepted in one cycle. m0_readdatavalid pulses 1 cycle after the read grant with 0xDEADBEEF. m1_readdatavalid stays 0.
- Both masters issue continuous reads (m0 addr 0, m1 addr 1) -> grants alternate m0,m1,m0,... starting with m0. Each readdatavalid comes 1 cycle after its grant. One grant per cycle.
- After clear, m1 writes 0x11223344 with be 4'b0101 to addr 3, then reads addr 3 -> returns 0x00220044.
- Read granted at cycle N, freeze=1 from N+1 for 3 cycles -> readdatavalid at N+1. No grants while frozen. After unfreeze the next grant goes to the master the pointer selects.
- reset_n pulled low with a read pending -> readdatavalid=0 and waitrequest=1 at once. On release the RAM is re-cleared and a read of addr 2 returns 0.
